// File: rtl/mulalu.sv
// mulalu: iterative 32x32 multiply / divide unit for the EX stage, feeding the HI/LO file.
// Latency: 33 cycles start-to-hilo_we for MUL and DIV (MUL is 1 cycle when MULALU_FAST_MUL_EN is defined).
// Backpressure: stall holds EX/IF/ID from the start cycle until DONE; flush aborts with no write-back.
// Optional feature macro: MULALU_FAST_MUL_EN (single-cycle MUL via a 33x33 signed multiplier).

`ifndef W_FUNC
`define W_FUNC 5
`endif
`ifndef W_DATA
`define W_DATA 32
`endif
`ifndef FUNC_MUL
`define FUNC_MUL 5'b11000
`endif
`ifndef FUNC_DIV
`define FUNC_DIV 5'b11010
`endif

module mulalu #(
  parameter int ITERS = 32,
  parameter int CNT_W = 5
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [`W_FUNC-1:0]   func,
  input  logic                 sign,
  input  logic [`W_DATA-1:0]   source_a,
  input  logic [`W_DATA-1:0]   source_b,
  input  logic                 flush,
  output logic                 stall,
  output logic                 busy,
  output logic                 hilo_we,
  output logic [`W_DATA-1:0]   hi,
  output logic [`W_DATA-1:0]   lo
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_MUL  = 2'd1,
    S_DIV  = 2'd2,
    S_DONE = 2'd3
  } state_t;

  state_t           state;
  logic [CNT_W-1:0] cnt;
  // MUL: {partial product high, remaining multiplier bits}; DIV: {partial remainder, dividend/quotient}
  logic [63:0]      acc;
  // MUL: |multiplicand|; DIV: |divisor|
  logic [31:0]      opnd;
  // raw dividend kept for the divide-by-zero remainder
  logic [31:0]      a_raw;
  logic             neg_q;
  logic             neg_r;
  logic             b_zero;
  logic             busy_r;
  logic [31:0]      hi_r;
  logic [31:0]      lo_r;

  logic             is_req;
  logic             start;
  logic             last;
  logic [31:0]      abs_a;
  logic [31:0]      abs_b;
  logic [32:0]      mul_sum;
  logic [63:0]      mul_next;
  logic [63:0]      mul_final;
  logic [32:0]      div_part;
  logic [32:0]      div_trial;
  logic             div_qbit;
  logic [31:0]      div_rem;
  logic [63:0]      div_next;
  logic [31:0]      div_q_final;
  logic [31:0]      div_r_final;

  // Request decode, operand magnitudes and one iteration step of each datapath
  always_comb begin
    is_req      = (func == `FUNC_MUL) || (func == `FUNC_DIV);
    start       = (state == S_IDLE) && !flush && is_req;
    last        = (cnt == CNT_W'(ITERS - 1));

    abs_a       = (sign && source_a[31]) ? (~source_a + 32'd1) : source_a;
    abs_b       = (sign && source_b[31]) ? (~source_b + 32'd1) : source_b;

    // Shift-add: add multiplicand when the current multiplier LSB is set, then shift right
    mul_sum     = {1'b0, acc[63:32]} + (acc[0] ? {1'b0, opnd} : 33'd0);
    mul_next    = {mul_sum, acc[31:1]};
    mul_final   = neg_q ? (~mul_next + 64'd1) : mul_next;

    // Restoring division: bring in next dividend bit, trial subtract, keep if non-negative.
    // 33 bits suffice: whenever the partial remainder overflows 32 bits it is already >= divisor.
    div_part    = {acc[63:32], acc[31]};
    div_trial   = div_part - {1'b0, opnd};
    div_qbit    = !div_trial[32];
    div_rem     = div_qbit ? div_trial[31:0] : div_part[31:0];
    div_next    = {div_rem, acc[30:0], div_qbit};

    // Divide by zero bypasses sign fixup entirely
    if (b_zero) begin
      div_q_final = 32'hFFFF_FFFF;
      div_r_final = a_raw;
    end else begin
      div_q_final = neg_q ? (~div_next[31:0] + 32'd1) : div_next[31:0];
      div_r_final = neg_r ? (~div_next[63:32] + 32'd1) : div_next[63:32];
    end
  end

`ifdef MULALU_FAST_MUL_EN
  logic signed [32:0] fast_a;
  logic signed [32:0] fast_b;
  logic signed [63:0] fast_prod;

  // Single-cycle product; extend by sign only for signed ops so one signed multiplier serves both
  always_comb begin
    fast_a    = {sign & source_a[31], source_a};
    fast_b    = {sign & source_b[31], source_b};
    fast_prod = 64'(fast_a) * 64'(fast_b);
  end
`endif

  // Control FSM and datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= S_IDLE;
      cnt    <= '0;
      acc    <= '0;
      opnd   <= '0;
      a_raw  <= '0;
      neg_q  <= 1'b0;
      neg_r  <= 1'b0;
      b_zero <= 1'b0;
      busy_r <= 1'b0;
      hi_r   <= '0;
      lo_r   <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (start) begin
            cnt    <= '0;
            a_raw  <= source_a;
            neg_q  <= sign & (source_a[31] ^ source_b[31]);
            neg_r  <= sign & source_a[31];
            b_zero <= (source_b == 32'd0);
            if (func == `FUNC_MUL) begin
`ifdef MULALU_FAST_MUL_EN
              hi_r   <= fast_prod[63:32];
              lo_r   <= fast_prod[31:0];
              state  <= S_DONE;
`else
              acc    <= {32'd0, abs_b};
              opnd   <= abs_a;
              busy_r <= 1'b1;
              state  <= S_MUL;
`endif
            end else begin
              acc    <= {32'd0, abs_a};
              opnd   <= abs_b;
              busy_r <= 1'b1;
              state  <= S_DIV;
            end
          end
        end

        S_MUL: begin
          if (flush) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else begin
            acc <= mul_next;
            cnt <= cnt + 1'b1;
            if (last) begin
              hi_r   <= mul_final[63:32];
              lo_r   <= mul_final[31:0];
              busy_r <= 1'b0;
              state  <= S_DONE;
            end
          end
        end

        S_DIV: begin
          if (flush) begin
            busy_r <= 1'b0;
            state  <= S_IDLE;
          end else begin
            acc <= div_next;
            cnt <= cnt + 1'b1;
            if (last) begin
              hi_r   <= div_r_final;
              lo_r   <= div_q_final;
              busy_r <= 1'b0;
              state  <= S_DONE;
            end
          end
        end

        default: begin
          // DONE: results already registered; never accepts a new op here
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Outputs: stall drops on flush so the redirect proceeds; write-back is suppressed by flush in DONE
  always_comb begin
    stall   = start || (busy_r && !flush);
    busy    = busy_r;
    hilo_we = (state == S_DONE) && !flush;
    hi      = hi_r;
    lo      = lo_r;
  end

endmodule
